// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 run controller.
//   ctrl_state_t - sequencer states (init -> ksa -> prga, each a GO/WAIT pair)
//   phase_t      - which datapath block currently owns the S memory port
//   KEY_W/BYTE_W - key and S-memory data widths
//   state_phase  - maps a sequencer state to the S-port owner
package arc4_pkg;

    localparam int KEY_W  = 24;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        INIT_GO,
        INIT_WAIT,
        KSA_GO,
        KSA_WAIT,
        PRGA_GO,
        PRGA_WAIT,
        DONE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_INIT,
        PH_KSA,
        PH_PRGA
    } phase_t;

    // The GO cycle already belongs to its phase so a block may write S
    // in the very cycle it is started.
    function automatic phase_t state_phase(input ctrl_state_t s);
        phase_t p;
        case (s)
            INIT_GO, INIT_WAIT: p = PH_INIT;
            KSA_GO,  KSA_WAIT:  p = PH_KSA;
            PRGA_GO, PRGA_WAIT: p = PH_PRGA;
            default:            p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/arc4_smem_mux.sv
// arc4_smem_mux: 3-to-1 combinational mux for the S memory write-side port.
//   phase_i              - owner select (PH_NONE drives an all-zero, no-write port)
//   init_*/ksa_*/prga_*  - addr/wrdata/wren request of each datapath block
//   s_addr_o/s_wrdata_o/s_wren_o - port to the single-port S memory
// A block that is not the owner never reaches memory, whatever its wren.
module arc4_smem_mux
    import arc4_pkg::*;
(
    input  phase_t            phase_i,
    input  logic [BYTE_W-1:0] init_addr_i,
    input  logic [BYTE_W-1:0] init_wrdata_i,
    input  logic              init_wren_i,
    input  logic [BYTE_W-1:0] ksa_addr_i,
    input  logic [BYTE_W-1:0] ksa_wrdata_i,
    input  logic              ksa_wren_i,
    input  logic [BYTE_W-1:0] prga_addr_i,
    input  logic [BYTE_W-1:0] prga_wrdata_i,
    input  logic              prga_wren_i,
    output logic [BYTE_W-1:0] s_addr_o,
    output logic [BYTE_W-1:0] s_wrdata_o,
    output logic              s_wren_o
);

    always_comb begin
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (phase_i)
            PH_INIT: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            PH_KSA: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            PH_PRGA: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: begin
                s_addr_o   = '0;
                s_wrdata_o = '0;
                s_wren_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arc4_ctrl.sv
// arc4_ctrl: sequencer for one ARC4 decryption run (init -> ksa -> prga).
//   clk, rst            - clock, synchronous active-high reset
//   en/rdy              - run request / controller idle
//   key, key_q          - key input, key latched on an accepted request
//   done                - one-cycle pulse at the end of a run
//   err                 - sticky watchdog flag (always 0 without the watchdog)
//   init_/ksa_/prga_en  - one-cycle start pulses to the datapath blocks
//   init_/ksa_/prga_rdy - datapath block idle indications
//   *_s_addr/_s_wrdata/_s_wren - S memory requests of the three blocks
//   s_addr/s_wrdata/s_wren     - muxed S memory write-side port
//   dbg_state           - current sequencer state
//   WDOG_CYCLES         - per-phase cycle limit, active with ARC4_CTRL_WDOG_EN
// Optional feature macro: ARC4_CTRL_WDOG_EN (per-phase watchdog).
//
// Handshake: a request is accepted on a clock edge where en=1 and rdy=1;
// en while rdy=0 is dropped, nothing is queued. Towards a datapath block,
// X_en is a one-cycle start pulse and X_rdy=1 means the block is idle; the
// block is considered finished when X_rdy rises again after the pulse.
module arc4_ctrl
    import arc4_pkg::*;
#(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic              done,
    output logic              err,
    output logic [KEY_W-1:0]  key_q,
    output logic              init_en,
    input  logic              init_rdy,
    output logic              ksa_en,
    input  logic              ksa_rdy,
    output logic              prga_en,
    input  logic              prga_rdy,
    input  logic [BYTE_W-1:0] init_s_addr,
    input  logic [BYTE_W-1:0] init_s_wrdata,
    input  logic              init_s_wren,
    input  logic [BYTE_W-1:0] ksa_s_addr,
    input  logic [BYTE_W-1:0] ksa_s_wrdata,
    input  logic              ksa_s_wren,
    input  logic [BYTE_W-1:0] prga_s_addr,
    input  logic [BYTE_W-1:0] prga_s_wrdata,
    input  logic              prga_s_wren,
    output logic [BYTE_W-1:0] s_addr,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output ctrl_state_t       dbg_state
);

    ctrl_state_t state_q, state_d;
    phase_t      phase_q;
    logic        armed_q, armed_d;
    logic        rdy_q, done_q;
    logic        init_en_q, ksa_en_q, prga_en_q;
    logic        wait_rdy;
    ctrl_state_t wait_next;
    logic        wdog_hit;

    // rdy of the block being waited on, and where to go once it finishes.
    always_comb begin
        wait_rdy  = 1'b0;
        wait_next = IDLE;
        case (state_q)
            INIT_WAIT: begin wait_rdy = init_rdy; wait_next = KSA_GO;  end
            KSA_WAIT:  begin wait_rdy = ksa_rdy;  wait_next = PRGA_GO; end
            PRGA_WAIT: begin wait_rdy = prga_rdy; wait_next = DONE;    end
            default:   begin wait_rdy = 1'b0;     wait_next = IDLE;    end
        endcase
    end

    // A block may still show rdy=1 for a cycle or more after its start
    // pulse. The armed flag is cleared on entry to WAIT and only set once
    // rdy has been seen low, so completion is a genuine rising rdy.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = INIT_GO;
            end
            INIT_GO: begin
                state_d = INIT_WAIT;
                armed_d = 1'b0;
            end
            KSA_GO: begin
                state_d = KSA_WAIT;
                armed_d = 1'b0;
            end
            PRGA_GO: begin
                state_d = PRGA_WAIT;
                armed_d = 1'b0;
            end
            INIT_WAIT, KSA_WAIT, PRGA_WAIT: begin
                if (armed_q && wait_rdy) begin
                    state_d = wait_next;
                end else if (wdog_hit) begin
                    state_d = DONE;
                end else if (!wait_rdy) begin
                    armed_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output is registered from the next state, so it lines up
    // exactly with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            phase_q   <= PH_NONE;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
            init_en_q <= 1'b0;
            ksa_en_q  <= 1'b0;
            prga_en_q <= 1'b0;
            key_q     <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            phase_q   <= state_phase(state_d);
            rdy_q     <= (state_d == IDLE);
            done_q    <= (state_d == DONE);
            init_en_q <= (state_d == INIT_GO);
            ksa_en_q  <= (state_d == KSA_GO);
            prga_en_q <= (state_d == PRGA_GO);
            if (en && rdy_q) key_q <= key;
        end
    end

`ifdef ARC4_CTRL_WDOG_EN
    logic [15:0] wdog_q;
    logic        err_q;
    logic        in_wait;

    assign in_wait  = (state_q == INIT_WAIT) || (state_q == KSA_WAIT) ||
                      (state_q == PRGA_WAIT);
    assign wdog_hit = (wdog_q == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == INIT_GO || state_q == KSA_GO || state_q == PRGA_GO)
                wdog_q <= '0;
            else if (in_wait)
                wdog_q <= wdog_q + 16'd1;

            // A normal completion in the same cycle takes priority.
            if (en && rdy_q)
                err_q <= 1'b0;
            else if (in_wait && wdog_hit && !(armed_q && wait_rdy))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

    assign rdy       = rdy_q;
    assign done      = done_q;
    assign init_en   = init_en_q;
    assign ksa_en    = ksa_en_q;
    assign prga_en   = prga_en_q;
    assign dbg_state = state_q;

    arc4_smem_mux u_smem_mux (
        .phase_i       (phase_q),
        .init_addr_i   (init_s_addr),
        .init_wrdata_i (init_s_wrdata),
        .init_wren_i   (init_s_wren),
        .ksa_addr_i    (ksa_s_addr),
        .ksa_wrdata_i  (ksa_s_wrdata),
        .ksa_wren_i    (ksa_s_wren),
        .prga_addr_i   (prga_s_addr),
        .prga_wrdata_i (prga_s_wrdata),
        .prga_wren_i   (prga_s_wren),
        .s_addr_o      (s_addr),
        .s_wrdata_o    (s_wrdata),
        .s_wren_o      (s_wren)
    );

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: directed bench for arc4_ctrl with behavioural init/ksa/prga
// models (busy 256/768/50 cycles) that all request S writes constantly.
module tb_arc4_ctrl;
  import arc4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en, rdy, done, err;
  logic [23:0] key, key_q;
  logic        init_en, ksa_en, prga_en;
  logic        s_wren;
  logic [7:0]  s_addr, s_wrdata;
  ctrl_state_t dbg_state;

  // ---------------- datapath block models ----------------
  logic [2:0] m_rdy;
  int         m_cnt[3];
  int         m_stale[3];
  int         busy_len[3];
  int         stale_len[3];
  bit         hang[3];
  logic [2:0] en_v;
  assign en_v = {prga_en, ksa_en, init_en};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_rdy[i]   <= 1'b1;
        m_cnt[i]   <= 0;
        m_stale[i] <= 0;
      end else if (en_v[i]) begin
        if (stale_len[i] > 0) begin
          m_stale[i] <= stale_len[i];
        end else begin
          m_rdy[i] <= 1'b0;
          m_cnt[i] <= busy_len[i];
        end
      end else if (m_stale[i] > 0) begin
        m_stale[i] <= m_stale[i] - 1;
        if (m_stale[i] == 1) begin
          m_rdy[i] <= 1'b0;
          m_cnt[i] <= busy_len[i];
        end
      end else if (m_cnt[i] > 0 && !hang[i]) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) m_rdy[i] <= 1'b1;
      end
    end
  end

  arc4_ctrl #(.WDOG_CYCLES(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .rdy           (rdy),
    .key           (key),
    .done          (done),
    .err           (err),
    .key_q         (key_q),
    .init_en       (init_en),
    .init_rdy      (m_rdy[0]),
    .ksa_en        (ksa_en),
    .ksa_rdy       (m_rdy[1]),
    .prga_en       (prga_en),
    .prga_rdy      (m_rdy[2]),
    .init_s_addr   (8'h11),
    .init_s_wrdata (8'hA1),
    .init_s_wren   (1'b1),
    .ksa_s_addr    (8'h22),
    .ksa_s_wrdata  (8'hB2),
    .ksa_s_wren    (1'b1),
    .prga_s_addr   (8'h33),
    .prga_s_wrdata (8'hC3),
    .prga_s_wren   (1'b1),
    .s_addr        (s_addr),
    .s_wrdata      (s_wrdata),
    .s_wren        (s_wren),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [1:0] exp_q[$];   // expected event order: 0 init,1 ksa,2 prga,3 done
  logic [1:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  int       cyc = 0;
  int       n_done = 0;
  int       init_cyc, ksa_cyc, prga_cyc, done_cyc;
  int       mux_err = 0;
  int       key_err = 0;
  bit       key_watch = 0;
  logic [23:0] exp_key;
  phase_t   exp_ph = PH_NONE;
  logic [16:0] exp_port;

  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (rst) begin
      exp_ph = PH_NONE;
    end else begin
      if (init_en) begin obs_q.push_back(2'd0); init_cyc = cyc; exp_ph = PH_INIT; end
      if (ksa_en)  begin obs_q.push_back(2'd1); ksa_cyc  = cyc; exp_ph = PH_KSA;  end
      if (prga_en) begin obs_q.push_back(2'd2); prga_cyc = cyc; exp_ph = PH_PRGA; end
      if (done)    begin obs_q.push_back(2'd3); done_cyc = cyc; n_done++; exp_ph = PH_NONE; end
    end
    case (exp_ph)
      PH_INIT: exp_port = {8'h11, 8'hA1, 1'b1};
      PH_KSA:  exp_port = {8'h22, 8'hB2, 1'b1};
      PH_PRGA: exp_port = {8'h33, 8'hC3, 1'b1};
      default: exp_port = 17'd0;
    endcase
    if ({s_addr, s_wrdata, s_wren} !== exp_port) mux_err++;
    if (key_watch && key_q !== exp_key) key_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [23:0] k);
    en  = 1'b1;
    key = k;
    @(negedge clk);
    en = 1'b0;
    check("rdy_busy", {31'd0, rdy}, 32'd0);
  endtask

  task automatic wait_done(input int limit);
    int n0;
    n0 = n_done;
    for (int i = 0; i < limit && n_done == n0; i++) @(negedge clk);
    check("done_seen", n_done - n0, 32'd1);
  endtask

  task automatic wait_ev(input int target, input int limit);
    for (int i = 0; i < limit && obs_q.size() < target; i++) @(negedge clk);
    check("ev_reached", {31'd0, obs_q.size() >= target}, 32'd1);
  endtask

  task automatic check_events(input int base);
    check("ev_count", obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
      check($sformatf("ev%0d", i), {30'd0, obs_q[base + i]}, {30'd0, exp_q[i]});
  endtask

  // ---------------- stimulus ----------------
  int base;
  int nd0;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    key = '0;
    busy_len  = '{256, 768, 50};
    stale_len = '{0, 0, 0};
    hang      = '{0, 0, 0};
    exp_q     = '{2'd0, 2'd1, 2'd2, 2'd3};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_rdy",     {31'd0, rdy},     32'd1);
    check("rst_init_en", {31'd0, init_en}, 32'd0);
    check("rst_ksa_en",  {31'd0, ksa_en},  32'd0);
    check("rst_prga_en", {31'd0, prga_en}, 32'd0);
    check("rst_s_wren",  {31'd0, s_wren},  32'd0);
    check("rst_key_q",   {8'd0, key_q},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_err",     {31'd0, err},     32'd0);

    // Run A: nominal run, key input changes after acceptance
    base    = obs_q.size();
    exp_key = 24'h1E4600;
    start_run(24'h1E4600);
    key       = 24'h5A5A5A;
    key_watch = 1'b1;
    wait_done(3000);
    @(negedge clk);
    check("a_rdy_after", {31'd0, rdy}, 32'd1);
    check("a_init_ksa", ksa_cyc - init_cyc, 32'd258);
    check("a_ksa_prga", prga_cyc - ksa_cyc, 32'd770);
    check("a_prga_done", done_cyc - prga_cyc, 32'd52);
    check_events(base);
    check("a_key_q", {8'd0, key_q}, 32'h1E4600);

    // Run B: en with a new key while ksa is busy is ignored
    base = obs_q.size();
    start_run(24'h1E4600);
    wait_ev(base + 2, 600);
    repeat (20) @(negedge clk);
    key = 24'hABCDEF;
    en  = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    check("b_key_hold", {8'd0, key_q}, 32'h1E4600);
    wait_done(3000);
    @(negedge clk);
    check("b_rdy_after", {31'd0, rdy}, 32'd1);
    check_events(base);
    check("b_key_err", key_err, 32'd0);
    key_watch = 1'b0;

    // Run C: prga keeps a stale rdy=1 for two cycles after its start pulse
    base = obs_q.size();
    stale_len[2] = 2;
    start_run(24'h1E4600);
    wait_done(3000);
    // en held into IDLE starts the next run straight away
    en  = 1'b1;
    key = 24'h0F0F0F;
    @(negedge clk);
    check("c_rdy_after", {31'd0, rdy}, 32'd1);
    check("c_prga_done", done_cyc - prga_cyc, 32'd54);
    check_events(base);
    stale_len[2] = 0;
    base = obs_q.size();
    @(negedge clk);
    en = 1'b0;
    check("d_b2b_init_en", {31'd0, init_en}, 32'd1);
    check("d_b2b_key_q", {8'd0, key_q}, 32'h0F0F0F);

    // Run E: reset in cycle 10 of PRGA_WAIT
    wait_ev(base + 3, 2000);
    nd0 = n_done;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("e_rdy",     {31'd0, rdy},     32'd1);
    check("e_prga_en", {31'd0, prga_en}, 32'd0);
    check("e_s_wren",  {31'd0, s_wren},  32'd0);
    check("e_done",    {31'd0, done},    32'd0);
    check("e_state",   32'(dbg_state),   32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("e_no_done", n_done - nd0, 32'd0);

    // Run F: ksa never returns rdy
    hang[1] = 1'b1;
    base = obs_q.size();
    start_run(24'h123456);
    wait_ev(base + 2, 600);
`ifdef ARC4_CTRL_WDOG_EN
    wait_done(400);
    check("f_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("f_rdy_after", {31'd0, rdy}, 32'd1);
`else
    nd0 = n_done;
    repeat (300) @(negedge clk);
    check("f_no_done", n_done - nd0, 32'd0);
    check("f_rdy",     {31'd0, rdy},   32'd0);
    check("f_err",     {31'd0, err},   32'd0);
    check("f_s_addr",  {24'd0, s_addr}, 32'h22);
    check("f_state",   32'(dbg_state), 32'(KSA_WAIT));
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hang[1] = 1'b0;
    check("f_err_clr", {31'd0, err}, 32'd0);
    check("f_rdy_rst", {31'd0, rdy}, 32'd1);

    // S port ownership over the whole run
    check("mux_isolation", mux_err, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
